// File: rtl/testpattern_pkg.sv
// Shared colour-bar definitions for the testpattern generator and checker.
// One field mapping keeps both ends agreeing on the column/row boundaries.
package testpattern_pkg;

    typedef enum logic [2:0] {
        RED,
        GREEN,
        BLUE,
        MAGENTA,
        CYAN,
        WHITE
    } field_t;

    typedef enum logic {
        WAIT_SOF,
        CHECK
    } state_t;

    // Boundaries are inclusive on the left/top field.
    function automatic field_t field_of(
        input int h,
        input int v,
        input int hpix,
        input int vpix
    );
        field_t f;
        if (v <= vpix / 2) begin
            if (h <= hpix / 3)
                f = RED;
            else if (h <= hpix * 2 / 3)
                f = GREEN;
            else
                f = BLUE;
        end else begin
            if (h <= hpix / 3)
                f = MAGENTA;
            else if (h <= hpix * 2 / 3)
                f = CYAN;
            else
                f = WHITE;
        end
        return f;
    endfunction

endpackage

// File: rtl/testpattern.sv
// Colour-bar pattern source: maps a pixel coordinate to its packed
// {red, green, blue} value with each channel fully on or fully off.
module testpattern
    import testpattern_pkg::*;
#(
    parameter int RED_BITS   = 5,
    parameter int GREEN_BITS = 6,
    parameter int BLUE_BITS  = 5,
    parameter int PIXEL_BITS = RED_BITS + GREEN_BITS + BLUE_BITS,
    parameter int HPIX       = 1920,
    parameter int VPIX       = 1080,
    parameter int HCTR_BITS  = $clog2(HPIX),
    parameter int VCTR_BITS  = $clog2(VPIX)
) (
    input  logic [HCTR_BITS-1:0]  h,
    input  logic [VCTR_BITS-1:0]  v,
    output logic [PIXEL_BITS-1:0] pixel
);

    field_t fld;
    logic [RED_BITS-1:0]   r;
    logic [GREEN_BITS-1:0] g;
    logic [BLUE_BITS-1:0]  b;

    always_comb begin
        fld = field_of(int'(h), int'(v), HPIX, VPIX);
        r = '0;
        g = '0;
        b = '0;
        case (fld)
            RED:     r = '1;
            GREEN:   g = '1;
            BLUE:    b = '1;
            MAGENTA: begin
                r = '1;
                b = '1;
            end
            CYAN:    begin
                g = '1;
                b = '1;
            end
            WHITE:   begin
                r = '1;
                g = '1;
                b = '1;
            end
            default: ;
        endcase
    end

    assign pixel = {r, g, b};

endmodule

// File: rtl/testpattern_checker.sv
// Sink-side checker: tracks pixel coordinates from de/sof, compares each
// pixel to the colour-bar reference and latches per-frame results.
module testpattern_checker
    import testpattern_pkg::*;
#(
    parameter int RED_BITS   = 5,
    parameter int GREEN_BITS = 6,
    parameter int BLUE_BITS  = 5,
    parameter int PIXEL_BITS = RED_BITS + GREEN_BITS + BLUE_BITS,
    parameter int HPIX       = 1920,
    parameter int VPIX       = 1080,
    parameter int HCTR_BITS  = $clog2(HPIX),
    parameter int VCTR_BITS  = $clog2(VPIX),
    parameter int ERR_BITS   = 16
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_enable,
    input  logic                  in_de,
    input  logic                  in_sof,
    input  logic [PIXEL_BITS-1:0] in_pixel,
    output logic                  out_frame_done,
    output logic                  out_frame_ok,
    output logic                  out_geom_err,
    output logic [ERR_BITS-1:0]   out_err_count,
    output logic [HCTR_BITS-1:0]  out_first_err_h,
    output logic [VCTR_BITS-1:0]  out_first_err_v
);

    localparam logic [HCTR_BITS-1:0] HMAX = HCTR_BITS'(HPIX - 1);
    localparam logic [VCTR_BITS-1:0] VMAX = VCTR_BITS'(VPIX - 1);

    state_t                  state_q;
    logic [HCTR_BITS-1:0]    h_q;
    logic [VCTR_BITS-1:0]    v_q;
    logic [ERR_BITS-1:0]     err_q;
    logic [HCTR_BITS-1:0]    fh_q;
    logic [VCTR_BITS-1:0]    fv_q;

    logic                    sof_px;
    logic                    accept;
    logic                    abort;
    logic                    last;
    logic                    hwrap;
    logic                    mis;
    logic [HCTR_BITS-1:0]    chk_h;
    logic [VCTR_BITS-1:0]    chk_v;
    logic [HCTR_BITS-1:0]    nh;
    logic [VCTR_BITS-1:0]    nv;
    logic [PIXEL_BITS-1:0]   exp_pixel;
    logic [ERR_BITS-1:0]     err_base;
    logic [HCTR_BITS-1:0]    fh_base;
    logic [VCTR_BITS-1:0]    fv_base;
    logic [ERR_BITS-1:0]     nxt_err;
    logic [HCTR_BITS-1:0]    nxt_fh;
    logic [VCTR_BITS-1:0]    nxt_fv;

    // An sof pixel is always (0,0) of a fresh frame, whatever the state.
    assign sof_px = in_de && in_sof;
    assign accept = in_de && (sof_px || state_q == CHECK);
    assign abort  = sof_px && state_q == CHECK;
    assign chk_h  = sof_px ? '0 : h_q;
    assign chk_v  = sof_px ? '0 : v_q;

    testpattern #(
        .RED_BITS   (RED_BITS),
        .GREEN_BITS (GREEN_BITS),
        .BLUE_BITS  (BLUE_BITS),
        .PIXEL_BITS (PIXEL_BITS),
        .HPIX       (HPIX),
        .VPIX       (VPIX),
        .HCTR_BITS  (HCTR_BITS),
        .VCTR_BITS  (VCTR_BITS)
    ) u_ref (
        .h     (chk_h),
        .v     (chk_v),
        .pixel (exp_pixel)
    );

    assign mis      = in_pixel != exp_pixel;
    assign err_base = sof_px ? '0 : err_q;
    assign fh_base  = sof_px ? '0 : fh_q;
    assign fv_base  = sof_px ? '0 : fv_q;

    // Count never wraps, so a zero base means no mismatch seen yet.
    assign nxt_err = (mis && err_base != '1)
                   ? err_base + ERR_BITS'(1) : err_base;
    assign nxt_fh  = (mis && err_base == '0) ? chk_h : fh_base;
    assign nxt_fv  = (mis && err_base == '0) ? chk_v : fv_base;

    assign hwrap = chk_h == HMAX;
    assign last  = hwrap && chk_v == VMAX;
    assign nh    = hwrap ? '0 : chk_h + HCTR_BITS'(1);
    assign nv    = hwrap ? chk_v + VCTR_BITS'(1) : chk_v;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q         <= WAIT_SOF;
            h_q             <= '0;
            v_q             <= '0;
            err_q           <= '0;
            fh_q            <= '0;
            fv_q            <= '0;
            out_frame_done  <= 1'b0;
            out_frame_ok    <= 1'b0;
            out_geom_err    <= 1'b0;
            out_err_count   <= '0;
            out_first_err_h <= '0;
            out_first_err_v <= '0;
        end else begin
            out_frame_done <= 1'b0;
            if (!in_enable) begin
                state_q <= WAIT_SOF;
                h_q     <= '0;
                v_q     <= '0;
            end else if (accept) begin
                err_q   <= nxt_err;
                fh_q    <= nxt_fh;
                fv_q    <= nxt_fv;
                h_q     <= nh;
                v_q     <= nv;
                state_q <= CHECK;
                if (abort) begin
                    out_frame_done  <= 1'b1;
                    out_frame_ok    <= 1'b0;
                    out_geom_err    <= 1'b1;
                    out_err_count   <= err_q;
                    out_first_err_h <= fh_q;
                    out_first_err_v <= fv_q;
                end
                if (last) begin
                    out_frame_done  <= 1'b1;
                    out_frame_ok    <= nxt_err == '0;
                    out_geom_err    <= 1'b0;
                    out_err_count   <= nxt_err;
                    out_first_err_h <= nxt_fh;
                    out_first_err_v <= nxt_fv;
                    state_q         <= WAIT_SOF;
                    h_q             <= '0;
                    v_q             <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_testpattern_checker.sv
// Bench for testpattern_checker on a 12x6 frame: table-driven frames with a
// result scoreboard, plus early-sof, reset and enable sequences.
module tb_testpattern_checker;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b1;
    logic        de    = 1'b0;
    logic        sof   = 1'b0;
    logic [15:0] px    = '0;

    logic        done, ok, geom;
    logic [15:0] errc;
    logic [3:0]  fh;
    logic [2:0]  fv;
    logic        done4, ok4, geom4;
    logic [3:0]  errc4;
    logic [3:0]  fh4;
    logic [2:0]  fv4;

    testpattern_checker #(
        .HPIX(12), .VPIX(6), .ERR_BITS(16)
    ) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_enable(en),
        .in_de(de), .in_sof(sof), .in_pixel(px),
        .out_frame_done(done), .out_frame_ok(ok),
        .out_geom_err(geom), .out_err_count(errc),
        .out_first_err_h(fh), .out_first_err_v(fv)
    );

    testpattern_checker #(
        .HPIX(12), .VPIX(6), .ERR_BITS(4)
    ) dut4 (
        .in_clk(clk), .in_rst_n(rst_n), .in_enable(en),
        .in_de(de), .in_sof(sof), .in_pixel(px),
        .out_frame_done(done4), .out_frame_ok(ok4),
        .out_geom_err(geom4), .out_err_count(errc4),
        .out_first_err_h(fh4), .out_first_err_v(fv4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;
    int n_push = 0;
    int n_done = 0;

    typedef struct {
        string name;
        bit    ok;
        bit    geom;
        int    err;
        int    fh;
        int    fv;
        int    cyc;
    } exp_t;

    typedef struct {
        string       name;
        int          bad_a;
        logic [15:0] val_a;
        int          bad_b;
        logic [15:0] val_b;
        bit          allzero;
        bit          gaps;
        bit          ok;
        int          err;
        int          fh;
        int          fv;
    } vec_t;

    exp_t sb[$];
    exp_t em;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    function automatic logic [15:0] model(input int idx);
        int h;
        int v;
        bit top;
        h   = idx % 12;
        v   = idx / 12;
        top = v < 4;
        if (h < 5)
            return top ? 16'hF800 : 16'hF81F;
        else if (h < 9)
            return top ? 16'h07E0 : 16'h07FF;
        else
            return top ? 16'h001F : 16'hFFFF;
    endfunction

    // Scoreboard side: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got pulse at cycle %0d, want none", cyc);
            end else begin
                em = sb.pop_front();
                chk({em.name, ":done_cycle"}, cyc, em.cyc);
                chk({em.name, ":ok"}, int'(ok), int'(em.ok));
                chk({em.name, ":geom"}, int'(geom), int'(em.geom));
                chk({em.name, ":err"}, int'(errc), em.err);
                chk({em.name, ":first_h"}, int'(fh), em.fh);
                chk({em.name, ":first_v"}, int'(fv), em.fv);
                chk({em.name, ":done4"}, int'(done4), 1);
                chk({em.name, ":ok4"}, int'(ok4), int'(em.ok));
                chk({em.name, ":geom4"}, int'(geom4), int'(em.geom));
                chk({em.name, ":err4"}, int'(errc4), em.err > 15 ? 15 : em.err);
                chk({em.name, ":first_h4"}, int'(fh4), em.fh);
                chk({em.name, ":first_v4"}, int'(fv4), em.fv);
            end
        end
    end

    task automatic drive(input bit d, input bit s, input logic [15:0] p);
        @(posedge clk);
        #1;
        de  = d;
        sof = s;
        px  = p;
    endtask

    task automatic push(input string nm, input bit o, input bit g,
                        input int e, input int h, input int v);
        exp_t x;
        x = '{nm, o, g, e, h, v, cyc + 1};
        sb.push_back(x);
        n_push++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic gap(input bit use_gaps);
        if (use_gaps)
            while ($urandom_range(0, 2) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
    endtask

    task automatic send_frame(input vec_t t, input bit abort_prev);
        logic [15:0] p;
        for (int i = 0; i < 72; i++) begin
            gap(t.gaps);
            p = model(i);
            if (i == t.bad_a) p = t.val_a;
            if (i == t.bad_b) p = t.val_b;
            if (t.allzero) p = 16'h0000;
            drive(1'b1, i == 0, p);
            if (i == 0 && abort_prev)
                push({t.name, ":abort"}, 1'b0, 1'b1, 0, 0, 0);
            if (i == 71)
                push(t.name, t.ok, 1'b0, t.err, t.fh, t.fv);
        end
    endtask

    task automatic send_run(input int start, input int n, input bit sof_first);
        for (int i = 0; i < n; i++)
            drive(1'b1, sof_first && i == 0, model((start + i) % 72));
    endtask

    task automatic chk_out(input string tag, input bit o, input int e);
        chk({tag, ":done"}, int'(done), 0);
        chk({tag, ":ok"}, int'(ok), int'(o));
        chk({tag, ":geom"}, int'(geom), 0);
        chk({tag, ":err"}, int'(errc), e);
        chk({tag, ":first_h"}, int'(fh), 0);
        chk({tag, ":first_v"}, int'(fv), 0);
        chk({tag, ":ok4"}, int'(ok4), int'(o));
        chk({tag, ":err4"}, int'(errc4), e);
        chk({tag, ":first_h4"}, int'(fh4), 0);
        chk({tag, ":first_v4"}, int'(fv4), 0);
    endtask

    initial begin
        tbl[0] = '{"clean",    -1, 16'h0000, -1, 16'h0000, 1'b0, 1'b1, 1'b1,  0,  0, 0};
        tbl[1] = '{"single",   41, 16'h0000, -1, 16'h0000, 1'b0, 1'b0, 1'b0,  1,  5, 3};
        tbl[2] = '{"boundary",  4, 16'h07E0, 57, 16'hFFFF, 1'b0, 1'b1, 1'b0,  1,  4, 0};
        tbl[3] = '{"lastpix",  71, 16'h001F, -1, 16'h0000, 1'b0, 1'b1, 1'b0,  1, 11, 5};
        tbl[4] = '{"two_err",   0, 16'h0000, 70, 16'h0000, 1'b0, 1'b0, 1'b0,  2,  0, 0};
        tbl[5] = '{"saturate", -1, 16'h0000, -1, 16'h0000, 1'b1, 1'b1, 1'b0, 72,  0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++)
            send_frame(tbl[i], 1'b0);
        idle(3);

        send_run(0, 40, 1'b1);
        send_frame(tbl[0], 1'b1);
        idle(2);
        send_run(0, 71, 1'b1);
        send_frame(tbl[0], 1'b1);
        idle(2);
        send_frame(tbl[5], 1'b0);
        idle(2);

        send_run(0, 30, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_run(31, 80, 1'b0);
        idle(3);
        chk_out("ignore_nosof", 1'b0, 0);

        send_frame(tbl[0], 1'b0);
        idle(2);
        send_run(0, 30, 1'b1);
        en = 1'b0;
        send_run(30, 3, 1'b0);
        en = 1'b1;
        send_run(33, 60, 1'b0);
        idle(3);
        chk_out("enable_abort", 1'b1, 0);

        send_frame(tbl[1], 1'b0);
        idle(5);

        chk("queue_empty", sb.size(), 0);
        chk("done_count", n_done, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/testpattern_checker.md
# testpattern_checker

Receive-side counterpart of the `testpattern` generator. It consumes a pixel stream (pixel data plus data-enable and start-of-frame marker) and tracks pixel coordinates itself. Each pixel is compared against the six-field colour-bar pattern, and per-frame pass/fail results are reported. It sits at the sink end of a video path, either in loopback benches or behind a capture interface, to prove that frames arrive intact and correctly ordered.

## Interface
- `RED_BITS`, 5, red channel width
- `GREEN_BITS`, 6, green channel width
- `BLUE_BITS`, 5, blue channel width
- `PIXEL_BITS`, RED_BITS+GREEN_BITS+BLUE_BITS, packed pixel width, `{red, green, blue}`
- `HPIX`, 1920, active pixels per line
- `VPIX`, 1080, active lines per frame
- `HCTR_BITS`, $clog2(HPIX), column counter width
- `VCTR_BITS`, $clog2(VPIX), row counter width
- `ERR_BITS`, 16, mismatch counter width
- `in_clk`  in  1  pixel clock; single clock domain
- `in_rst_n`  in  1  asynchronous, active-low reset
- `in_enable`  in  1  checker enable; low aborts any frame in progress
- `in_de`  in  1  pixel valid; gaps allowed anywhere
- `in_sof`  in  1  qualifies the pixel sampled with `in_de` as (0,0); ignored when `in_de` is low
- `in_pixel`  in  PIXEL_BITS  pixel data
- `out_frame_done`  out  1  one-cycle pulse when a frame result is latched
- `out_frame_ok`  out  1  last frame had zero mismatches and no geometry error
- `out_geom_err`  out  1  last frame was cut short by an early `in_sof`
- `out_err_count`  out  ERR_BITS  saturating mismatch count of the last frame
- `out_first_err_h`  out  HCTR_BITS  column of the first mismatch in the last frame; 0 if none
- `out_first_err_v`  out  VCTR_BITS  row of the first mismatch in the last frame; 0 if none

## Operation
- States: `WAIT_SOF` and `CHECK`. Reset state is `WAIT_SOF`.
- **`WAIT_SOF`:** pixels without `in_sof` are discarded.
  - On `in_de && in_sof`, the pixel is checked as (0,0), the per-frame accumulators are cleared, and the state moves to `CHECK` with h=1, v=0.
  - If HPIX=1, h wraps to 0 and v=1.
- **`CHECK`:** each `in_de` cycle checks the pixel at (h,v), then advances the counters.
  - At h==HPIX-1, h wraps to 0 and v increments.
  - At (HPIX-1, VPIX-1) the frame is complete: results are latched, `out_frame_done` pulses, and the state returns to `WAIT_SOF`.
- **Expected colour:** each channel is all-ones or all-zeros.
  - Top half (v <= VPIX/2): red for h <= HPIX/3, green for HPIX/3 < h <= HPIX*2/3, blue otherwise.
  - Bottom half (v > VPIX/2): magenta (R+B), cyan (G+B), white, using the same column boundaries.
  - Divisions are integer divisions; the comparisons are inclusive exactly as stated.
- **Mismatch rule:** any bit difference over the full `PIXEL_BITS`.
  - The error count increments and saturates at 2^ERR_BITS-1.
  - The first mismatch in a frame captures (h,v).
- **Early SOF:** `in_de && in_sof` while in `CHECK`, including at (HPIX-1, VPIX-1).
  - The current frame is latched with geom_err=1 and ok=0, and `out_frame_done` pulses.
  - The same pixel starts a new frame as (0,0) and is checked against the new frame. The state stays `CHECK`.
- **`in_enable` low:** forces `WAIT_SOF` and discards the partial frame. No done pulse; outputs hold their last latched values.
- `in_de` low in any state: no counter or accumulator change.

## Timing
- Reset: all outputs 0, counters 0, state `WAIT_SOF`. This takes effect immediately and asynchronously, including mid-frame.
- Result latency is 1 cycle. The final (or aborting) pixel is sampled at edge k. All result outputs update at edge k, already including that pixel's comparison. `out_frame_done` is high for the single cycle following edge k.
- Results are stable until the next frame completes or aborts, or until reset.
- Throughput: one pixel per clock, with no back-pressure.
- Back-to-back frames: an `in_sof` pixel on the cycle right after the completing pixel is accepted as (0,0).

## Structure
- Shared package `testpattern_pkg`:
  - colour-field enum (RED, GREEN, BLUE, MAGENTA, CYAN, WHITE)
  - checker state enum
  - function mapping (h, v, HPIX, VPIX) to a field, so the generator and checker share one boundary definition
- Sub-module: instantiate `testpattern` as the expected-pixel reference, driven by the internal h/v counters and using identical parameters.
- The counters, state machine, accumulators and result registers are local.

## Test plan
All scenarios use HPIX=12, VPIX=6, 5/6/5 bits and ERR_BITS=16.
- **Clean frame:** send `in_sof` plus 72 pattern pixels with random `in_de` gaps. Expect exactly one done pulse, one cycle after the 72nd pixel, with ok=1, geom_err=0, err_count=0.
- **Single corruption:** pixel (5,3) is sent as 16'h0000 instead of 16'h07E0. Expect err_count=1, first_err=(5,3), ok=0.
- **Boundary inclusivity:** pixel (4,0) is sent as green 16'h07E0 where red 16'hF800 is expected, and pixel (9,4) is sent as white where white is expected. Expect err_count=1, first_err=(4,0).
- **Early SOF:** `in_sof` arrives on pixel 40. Expect a done pulse with geom_err=1 and ok=0. The following clean 72-pixel frame must then give ok=1 and geom_err=0.
- **Saturation:** with ERR_BITS=4, all 72 pixels are sent as 16'h0000. Expect err_count=15, first_err=(0,0).
- **Reset / enable:** assert `in_rst_n`=0 mid-frame and expect all outputs 0 immediately. Drop `in_enable` mid-frame and expect no done pulse. Pixels sent without `in_sof` afterwards must be ignored.
